// File: rtl/icache_way1.sv
// icache_way1: direct-mapped read-only instruction cache for the way1 fetch port.
// Register-based line storage, word-by-word refill from backing memory.
module icache_way1 #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        request_i,
    input  logic [31:0] instAddr_i,
    input  logic        jumpFlag_i,
    input  logic        invalidate_i,
    output logic        dataOk_o,
    output logic [31:0] inst_o,
    output logic        memRequest_o,
    output logic [31:0] memAddr_o,
    input  logic        memDataOk_i,
    input  logic [31:0] memData_i
);

    localparam int OFF  = $clog2(WORDS);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - OFF - IDX;
    localparam logic [OFF-1:0] K_LAST = OFF'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESP
    } state_t;

    state_t           state;
    logic [29:0]      req_word;
    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags  [LINES];
    logic [31:0]      words [LINES*WORDS];
    logic [OFF-1:0]   k;
    logic             killed;
    logic             inv_pend;

    logic [TAGW-1:0]  req_tag;
    logic [IDX-1:0]   req_idx;
    logic [OFF-1:0]   req_off;
    logic             hit;
    logic             beat;
    logic             last_beat;
    logic             unused_lsb;

    assign req_tag    = req_word[29:OFF+IDX];
    assign req_idx    = req_word[OFF+IDX-1:OFF];
    assign req_off    = req_word[OFF-1:0];
    assign unused_lsb = ^instAddr_i[1:0];

    // An invalidate arriving in the lookup cycle must not let stale data hit.
    assign hit = valid[req_idx]
              && (tags[req_idx] == req_tag)
              && !invalidate_i;

    assign beat      = (state == REFILL) && memDataOk_i;
    assign last_beat = beat && (k == K_LAST);

    // Response pulse is suppressed when a jump flushes the fetch in that cycle.
    assign dataOk_o     = (state == RESP) && !jumpFlag_i;
    assign memRequest_o = (state == REFILL);
    assign memAddr_o    = (state == REFILL)
                        ? {req_tag, req_idx, k, 2'b00}
                        : 32'h0;

    // Tag and data arrays: written only by refill beats, never reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            words[{req_idx, k}] <= memData_i;
        end
        if (last_beat) begin
            tags[req_idx] <= req_tag;
        end
    end

    // Fetch control FSM with valid bits, response word and refill bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            req_word <= '0;
            valid    <= '0;
            k        <= '0;
            killed   <= 1'b0;
            inv_pend <= 1'b0;
            inst_o   <= 32'h0;
        end else begin
            // Outside a refill, invalidates (new or deferred) clear every line.
            if ((state != REFILL) && (invalidate_i || inv_pend)) begin
                valid    <= '0;
                inv_pend <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!jumpFlag_i && request_i) begin
                        req_word <= instAddr_i[31:2];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (jumpFlag_i) begin
                        state <= IDLE;
                    end else if (hit) begin
                        inst_o <= words[{req_idx, req_off}];
                        state  <= RESP;
                    end else begin
                        if (!invalidate_i) begin
                            valid[req_idx] <= 1'b0;
                        end
                        k     <= '0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (jumpFlag_i) begin
                        killed <= 1'b1;
                    end
                    if (invalidate_i) begin
                        inv_pend <= 1'b1;
                    end
                    if (beat) begin
                        if (k == req_off) begin
                            inst_o <= memData_i;
                        end
                        k <= k + 1'b1;
                    end
                    if (last_beat) begin
                        valid[req_idx] <= 1'b1;
                        killed         <= 1'b0;
                        state <= (killed || jumpFlag_i) ? IDLE : RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_way1.sv
// tb_icache_way1: randomized fetch traffic against a line-level cache model.
// Memory responder returns 0x1000 + address after a per-beat latency.
module tb_icache_way1;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        request_i;
    logic [31:0] instAddr_i;
    logic        jumpFlag_i;
    logic        invalidate_i;
    logic        dataOk_o;
    logic [31:0] inst_o;
    logic        memRequest_o;
    logic [31:0] memAddr_o;
    logic        memDataOk_i;
    logic [31:0] memData_i;

    icache_way1 #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .request_i    (request_i),
        .instAddr_i   (instAddr_i),
        .jumpFlag_i   (jumpFlag_i),
        .invalidate_i (invalidate_i),
        .dataOk_o     (dataOk_o),
        .inst_o       (inst_o),
        .memRequest_o (memRequest_o),
        .memAddr_o    (memAddr_o),
        .memDataOk_i  (memDataOk_i),
        .memData_i    (memData_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int lat_fix = 2;
    int trig = 1;

    logic [31:0] addr_log[$];

    // Reference model: one valid flag and tag per line.
    bit          mv [LINES];
    logic [23:0] mt [LINES];

    function automatic logic [31:0] mfn(logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 0;
    endtask

    // Backing memory: answers each word request after a latency.
    initial begin
        int wait_cnt;
        wait_cnt = -1;
        memDataOk_i = 1'b0;
        memData_i = 32'h0;
        forever begin
            @(negedge clk);
            memDataOk_i = 1'b0;
            if (memRequest_o) begin
                if (wait_cnt < 0)
                    wait_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    memDataOk_i = 1'b1;
                    memData_i = mfn(memAddr_o);
                    addr_log.push_back(memAddr_o);
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
            end
        end
    end

    // jmode: 0 plain, 1 jump during refill, 2 invalidate during refill.
    task automatic fetch(input logic [31:0] a, input int jmode);
        int idx;
        logic [23:0] tg;
        bit hit, act, fired, prev_ok, done;
        int cyc, oks, lat;
        logic [31:0] got;
        idx = int'(a[7:4]);
        tg = a[31:8];
        hit = mv[idx] && (mt[idx] == tg);
        act = 0; fired = 0; prev_ok = 0; done = 0;
        cyc = 0; oks = 0; lat = -1; got = 32'h0;
        addr_log.delete();
        @(negedge clk);
        request_i = 1'b1;
        instAddr_i = a;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            jumpFlag_i = 1'b0;
            invalidate_i = 1'b0;
            if (act) begin
                if (jmode == 1) begin
                    jumpFlag_i = 1'b1;
                    request_i = 1'b0;
                end else begin
                    invalidate_i = 1'b1;
                end
                act = 0;
                fired = 1;
            end
            #1;
            if (dataOk_o) begin
                chk("no_double_ok", 32'(prev_ok), 32'd0);
                oks++;
                got = inst_o;
                lat = cyc;
                request_i = 1'b0;
                done = 1;
            end
            prev_ok = dataOk_o;
            if (jmode != 0 && !fired && memRequest_o
                && addr_log.size() >= trig)
                act = 1;
            if (jmode == 1 && fired && !memRequest_o) done = 1;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        request_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            jumpFlag_i = 1'b0;
            invalidate_i = 1'b0;
            #1;
            if (dataOk_o) oks++;
        end
        chk("ok_count", 32'(oks), (jmode == 1) ? 32'd0 : 32'd1);
        if (jmode != 1 && oks > 0) chk("inst", got, mfn({a[31:2], 2'b00}));
        chk("miss", 32'(addr_log.size() != 0), 32'(!hit));
        if (hit) chk("hit_lat", 32'(lat), 32'd2);
        if (!hit) begin
            chk("beats", 32'(addr_log.size()), 32'(WORDS));
            for (int i = 0; i < addr_log.size() && i < WORDS; i++)
                chk("beat_addr", addr_log[i], {a[31:4], 2'(i), 2'b00});
            mv[idx] = 1;
            mt[idx] = tg;
        end
        if (jmode == 2) model_clear();
    endtask

    task automatic inv_idle();
        @(negedge clk);
        invalidate_i = 1'b1;
        @(negedge clk);
        invalidate_i = 1'b0;
        model_clear();
    endtask

    initial begin
        int started;
        reset_n = 1'b0;
        request_i = 1'b0;
        instAddr_i = 32'h0;
        jumpFlag_i = 1'b0;
        invalidate_i = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dataok", 32'(dataOk_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_memreq", 32'(memRequest_o), 32'd0);
        chk("rst_memaddr", memAddr_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        lat_fix = 2;
        fetch(32'h08, 0);
        fetch(32'h0C, 0);
        fetch(32'h100, 0);
        fetch(32'h00, 0);
        trig = 1;
        fetch(32'h40, 1);
        fetch(32'h44, 0);
        inv_idle();
        fetch(32'h00, 0);
        fetch(32'h80, 2);
        fetch(32'h80, 0);

        addr_log.delete();
        @(negedge clk);
        request_i = 1'b1;
        instAddr_i = 32'h94;
        started = 0;
        for (int c = 0; c < 50 && !started; c++) begin
            @(negedge clk);
            #1;
            if (memRequest_o) started = 1;
        end
        chk("rst_setup", 32'(started), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        request_i = 1'b0;
        #1;
        chk("mid_rst_memreq", 32'(memRequest_o), 32'd0);
        chk("mid_rst_memaddr", memAddr_o, 32'd0);
        chk("mid_rst_dataok", 32'(dataOk_o), 32'd0);
        chk("mid_rst_inst", inst_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        fetch(32'h94, 0);

        lat_fix = -1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int op, idx;
            bit miss;
            a = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            idx = int'(a[7:4]);
            miss = !(mv[idx] && mt[idx] == a[31:8]);
            op = $urandom_range(0, 9);
            trig = $urandom_range(0, WORDS - 1);
            if (op == 0) inv_idle();
            else if (op == 1 && miss) fetch(a, 1);
            else if (op == 2 && miss) fetch(a, 2);
            else fetch(a, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_way1.md
# icache_way1

Direct-mapped, read-only instruction cache that answers the way1 instruction-fetch request (`request`/`instAddr` → `dataOk`/`inst`). It sits between the way1 fetch unit and the backing instruction memory. Misses refill a full line, one word per memory transaction. Jump flushes cancel the outstanding response, and an invalidate input clears the whole cache.

## Interface
Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2
- WORDS, 4, 32-bit words per line; power of 2, ≥2

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- request_i  in  1  fetch request from IFU; held high with stable address until dataOk_o
- instAddr_i  in  32  fetch address; bits [1:0] ignored
- jumpFlag_i  in  1  flush: cancel the in-flight fetch
- invalidate_i  in  1  clear all valid bits (fence.i)
- dataOk_o  out  1  one-cycle pulse; inst_o valid in the same cycle
- inst_o  out  32  fetched instruction
- memRequest_o  out  1  backing-memory word request; held until memDataOk_i
- memAddr_o  out  32  word-aligned backing-memory address
- memDataOk_i  in  1  memory data valid pulse
- memData_i  in  32  memory read data

## Operation
- Address split: OFF = log2(WORDS) word-offset bits at [OFF+1:2], IDX = log2(LINES) index bits above those, tag = remaining upper bits (30-OFF-IDX wide).
- Storage: per-line valid bit, tag register and WORDS data words, all register-based. Reads are combinational from the registered request address.
- States: IDLE, LOOKUP, REFILL, RESP.
- IDLE:
  - jumpFlag_i has priority: the request is not sampled that cycle.
  - Otherwise request_i=1 latches instAddr_i into reqAddr → LOOKUP.
- LOOKUP:
  - jumpFlag_i → IDLE.
  - Hit (valid && tag match): register the word into inst_o → RESP.
  - Miss: clear the line's valid bit, reset the word counter k to 0 → REFILL.
- REFILL:
  - memRequest_o=1, memAddr_o = {reqTag, reqIdx, k, 2'b00}.
  - On memDataOk_i: write memData_i to word k. If k equals the request offset, also capture it as the response word. Then k++.
  - On the beat with k=WORDS-1: write the tag, set valid, then go to RESP; if the killed flag is set, go to IDLE instead.
  - jumpFlag_i during REFILL sets the killed flag. The refill always completes, because the memory transaction cannot be aborted. The flag clears on exit.
- RESP:
  - dataOk_o=1 for exactly one cycle, then → IDLE.
  - If jumpFlag_i is high in this cycle, dataOk_o is forced to 0.
- invalidate_i:
  - In IDLE, LOOKUP or RESP: clears all valid bits at the next edge. An in-progress LOOKUP sees the cleared state the following cycle and does not hit on that edge's data.
  - In REFILL: recorded as pending and applied on the cycle after the refill exits, including the freshly filled line. The response for the current fetch is still delivered.
- Reset (async, any state):
  - state=IDLE, all valid=0, k=0, killed=0, pending invalidate=0.
  - dataOk_o=0, inst_o=0, memRequest_o=0, memAddr_o=0.
  - Tag and data arrays need not be reset.

## Timing
- Hit: request sampled at edge N (IDLE) → LOOKUP in cycle N+1 → dataOk_o high in cycle N+2. Latency 2 cycles. Back-to-back hits: one response per 3 cycles.
- Miss with memory latency L (memDataOk_i L cycles after memRequest_o rises): dataOk_o arrives 2 + WORDS·(L+1) cycles after the request edge, ±1 per beat boundary as implemented; the verifier checks ordering, not the exact count.
- memRequest_o:
  - Rises the cycle after LOOKUP detects the miss.
  - Stays high across beats; memAddr_o advances the cycle after each memDataOk_i.
  - Drops the cycle after the last beat.
- memDataOk_i outside REFILL is ignored.
- dataOk_o is never high on two consecutive cycles and never high outside RESP.
- request_i is sampled only in IDLE. A request still held after dataOk_o is re-sampled as a new fetch; the IFU must change or drop it in the dataOk_o cycle.

## Test plan
- Cold miss: reset, request 0x0000_0008, memory returns 0x1000+addr with L=2 → memAddr_o sequence 0x0,0x4,0x8,0xC; dataOk_o pulses once with inst_o=0x1008.
- Hit after fill: request 0x0000_000C → dataOk_o exactly 2 cycles after the request edge, inst_o=0x100C, memRequest_o stays 0.
- Conflict miss: request 0x0000_0100 (same index, LINES=16, WORDS=4) → refill of 0x100..0x10C, inst_o=0x1100. Then request 0x0000_0000 → miss again.
- Jump during refill: request 0x40, pulse jumpFlag_i on the second beat → all 4 beats complete, no dataOk_o. A subsequent request for 0x44 hits in 2 cycles.
- Invalidate: after filling 0x0, pulse invalidate_i in IDLE → request 0x0 misses and memRequest_o rises. Repeat with invalidate_i during REFILL → current response delivered, next access to that line misses.
- Reset mid-refill: assert reset_n=0 during REFILL → outputs 0 immediately. After release, the request for the same line misses.
